// File: rtl/mips_cpu_mem_arbiter.sv
// mips_cpu_mem_arbiter: round-robin share of one Avalon memory port between instruction fetch and data access
module mips_cpu_mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        owner,
  output logic        bus_error
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE, RESP} state_t;
  state_t      r_state;
  logic        r_last_grant;
  logic        r_write;
  logic [31:0] r_wd_cnt;
  logic        w_grant_d;
  logic        w_wr;
  logic        w_accept;
  logic        w_expire;
  // data wins only when alone or when instruction was served last
  assign w_grant_d = d_req && (!if_req || !r_last_grant);
  assign w_wr      = w_grant_d && d_write;
  assign w_accept  = (mem_read || mem_write) && !mem_waitrequest;
  assign w_expire  = (TIMEOUT != 0) && mem_waitrequest && (r_wd_cnt == 32'(TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_last_grant   <= 1'b1;
      r_write        <= 1'b0;
      r_wd_cnt       <= '0;
      owner          <= 1'b0;
      bus_error      <= 1'b0;
      if_ready       <= 1'b0;
      d_ready        <= 1'b0;
      if_rdata       <= '0;
      d_rdata        <= '0;
      mem_address    <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      mem_byteenable <= '0;
    end else begin
      case (r_state)
        IDLE: if (if_req || d_req) begin
          owner          <= w_grant_d;
          r_last_grant   <= w_grant_d;
          r_write        <= w_wr;
          r_wd_cnt       <= '0;
          mem_address    <= w_grant_d ? d_addr : if_addr;
          mem_read       <= !w_wr;
          mem_write      <= w_wr;
          mem_writedata  <= w_wr ? d_wdata : 32'd0;
          mem_byteenable <= w_grant_d ? d_byteenable : 4'hf;
          r_state        <= ISSUE;
        end
        ISSUE: if (w_accept) begin
          mem_read      <= 1'b0;
          mem_write     <= 1'b0;
          mem_writedata <= '0;
          r_state       <= DONE;
        end else if (w_expire) begin
          mem_read      <= 1'b0;
          mem_write     <= 1'b0;
          mem_writedata <= '0;
          bus_error     <= 1'b1;
          if_ready      <= !owner;
          d_ready       <= owner;
          if_rdata      <= '0;
          d_rdata       <= '0;
          r_state       <= RESP;
        end else begin
          r_wd_cnt <= r_wd_cnt + 32'd1;
        end
        DONE: begin
          if_ready <= !owner;
          d_ready  <= owner;
          if_rdata <= (!owner && !r_write) ? mem_readdata : 32'd0;
          d_rdata  <= (owner && !r_write) ? mem_readdata : 32'd0;
          r_state  <= RESP;
        end
        RESP: begin
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
          if_rdata <= '0;
          d_rdata  <= '0;
          r_state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// tb_mips_cpu_mem_arbiter: directed checks of fetch, stalled write, round-robin, watchdog and reset
module tb_mips_cpu_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_byteenable = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata = '0;
  logic        owner;
  logic        bus_error;
  int          n_chk = 0;
  int          n_err = 0;
  int          n_strobe = 0;
  int          wcnt = 0;
  int          wait_n = 0;
  logic        stuck = 1'b0;
  logic [31:0] rd_val = '0;
  int          cyc;
  int          s0;

  mips_cpu_mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .owner(owner), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  // memory: wait_n stall cycles per access (or forever when stuck), readdata the cycle after acceptance
  assign mem_waitrequest = (mem_read || mem_write) && (stuck || wcnt < wait_n);
  always @(posedge clk) begin
    wcnt <= (rst || !(mem_read || mem_write) || !mem_waitrequest) ? 0 : wcnt + 1;
    mem_readdata <= ((mem_read || mem_write) && !mem_waitrequest) ? rd_val : 32'd0;
  end
  always @(negedge clk) if (mem_read || mem_write) n_strobe++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(output int c);
    c = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (if_ready || d_ready) begin
        c = i;
        return;
      end
    end
    chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ctl"}, {26'd0, if_ready, d_ready, mem_read, mem_write, owner, bus_error}, 32'd0);
    chk({tag, "_addr"}, mem_address, 32'd0);
    chk({tag, "_data"}, mem_writedata | if_rdata | d_rdata | {28'd0, mem_byteenable}, 32'd0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk_idle_outs("reset");

    // zero-wait instruction fetch
    if_req = 1'b1;
    if_addr = 32'hBFC00000;
    rd_val = 32'h8C220004;
    s0 = n_strobe;
    @(negedge clk);
    chk("if_rd", {29'd0, mem_read, mem_write, owner}, 32'b100);
    chk("if_addr", mem_address, 32'hBFC00000);
    chk("if_be", {28'd0, mem_byteenable}, 32'hf);
    @(negedge clk);
    chk("if_done", {30'd0, mem_read, if_ready}, 32'd0);
    @(negedge clk);
    chk("if_ready", {30'd0, if_ready, d_ready}, 32'b10);
    chk("if_rdata", if_rdata, 32'h8C220004);
    if_req = 1'b0;
    @(negedge clk);
    chk("if_pulse", {31'd0, if_ready}, 32'd0);
    chk("if_strobes", n_strobe - s0, 32'd1);

    // stalled data write, inputs disturbed after grant
    d_req = 1'b1;
    d_write = 1'b1;
    d_addr = 32'h1000;
    d_wdata = 32'hDEADBEEF;
    d_byteenable = 4'b0011;
    wait_n = 3;
    rd_val = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d_addr = 32'hFFFF0000;
      d_wdata = 32'h0;
      d_byteenable = 4'b1100;
      chk("wr_strobe", {30'd0, mem_write, mem_read}, 32'b10);
      chk("wr_addr", mem_address, 32'h1000);
      chk("wr_data", mem_writedata, 32'hDEADBEEF);
      chk("wr_be", {28'd0, mem_byteenable}, 32'h3);
    end
    @(negedge clk);
    chk("wr_done", {31'd0, mem_write} | mem_writedata, 32'd0);
    @(negedge clk);
    chk("wr_ready", {30'd0, if_ready, d_ready}, 32'b01);
    chk("wr_rdata", d_rdata, 32'd0);
    chk("wr_owner", {31'd0, owner}, 32'd1);
    d_req = 1'b0;
    d_write = 1'b0;
    wait_n = 0;
    @(negedge clk);

    // contention from reset: strict alternation, 4 cycles per access
    do_reset();
    if_req = 1'b1;
    d_req = 1'b1;
    if_addr = 32'h00400000;
    d_addr = 32'h10010000;
    rd_val = 32'hA5A5F00F;
    for (int k = 0; k < 4; k++) begin
      wait_ready(cyc);
      chk("rr_owner", {31'd0, owner}, 32'(k % 2));
      chk("rr_ready", {30'd0, if_ready, d_ready}, (k % 2) ? 32'b01 : 32'b10);
      chk("rr_rdata", (k % 2) ? d_rdata : if_rdata, 32'hA5A5F00F);
      chk("rr_lat", 32'(cyc), (k == 0) ? 32'd3 : 32'd4);
    end
    if_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);

    // watchdog abort on a stuck data read
    stuck = 1'b1;
    d_req = 1'b1;
    d_addr = 32'h2000;
    s0 = n_strobe;
    wait_ready(cyc);
    chk("wd_strobes", n_strobe - s0, 32'd8);
    chk("wd_lat", 32'(cyc), 32'd9);
    chk("wd_ready", {30'd0, if_ready, d_ready}, 32'b01);
    chk("wd_rdata", d_rdata, 32'd0);
    chk("wd_err", {31'd0, bus_error}, 32'd1);
    d_req = 1'b0;
    stuck = 1'b0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h4;
    rd_val = 32'h11112222;
    wait_ready(cyc);
    chk("wd_next_rdata", if_rdata, 32'h11112222);
    chk("wd_sticky", {31'd0, bus_error}, 32'd1);
    if_req = 1'b0;
    @(negedge clk);

    // reset in the middle of a stall
    stuck = 1'b1;
    d_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("mr_stall", {31'd0, mem_read}, 32'd1);
    rst = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    chk_idle_outs("mr_reset");
    rst = 1'b0;
    stuck = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h80000180;
    rd_val = 32'h3C1A8000;
    wait_ready(cyc);
    chk("mr_lat", 32'(cyc), 32'd3);
    chk("mr_rdata", if_rdata, 32'h3C1A8000);
    chk("mr_err", {31'd0, bus_error}, 32'd0);
    if_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
